// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout, FSM encoding and divisor clamping.
package uart_pkg;

  localparam logic [1:0] TXDATA_OFF  = 2'd0;
  localparam logic [1:0] STATUS_OFF  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFF = 2'd2;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_OVF   = 3;
  localparam int unsigned STAT_COUNT = 4;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // Shorter bit periods would break the 0..div-1 baud counter.
  function automatic logic [15:0] clamp_div(input logic [15:0] raw);
    return (raw < MIN_DIV) ? MIN_DIV : raw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When full, wptr == rptr: the popped entry is read before this overwrite.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and frame FSM. Reads are combinational and side-effect free.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        idle
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            hit, push_req, baud_wr, ovf_clr, drop, pop, busy;
  logic [1:0]      off;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic [4:0]      count5;
  logic            unused_bits;

  logic [15:0] baud_q, cnt_q, cnt_d, div_q, div_d;
  logic        ovf_q, tx_q, tx_d, idle_q;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  tx_state_e   state_q, state_d;

  assign hit      = (address[31:4] == BASE_ADDR[31:4]);
  assign off      = address[3:2];
  assign push_req = hit && we && (off == TXDATA_OFF);
  assign baud_wr  = hit && we && (off == BAUDDIV_OFF);
  assign ovf_clr  = hit && we && (off == STATUS_OFF) && data_in[STAT_OVF];
  assign drop     = push_req && fifo_full && !pop;
  assign busy     = (state_q != StIdle);
  assign count5   = 5'(fifo_count);
  assign unused_bits = ^{address[1:0], data_in[31:16]};

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .wdata_i (data_in[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    data_out = '0;
    if (hit) begin
      case (off)
        STATUS_OFF: begin
          data_out[STAT_BUSY]        = busy;
          data_out[STAT_FULL]        = fifo_full;
          data_out[STAT_EMPTY]       = fifo_empty;
          data_out[STAT_OVF]         = ovf_q;
          data_out[STAT_COUNT +: 5]  = count5;
        end
        BAUDDIV_OFF: data_out[15:0] = baud_q;
        default:     data_out = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    div_d   = div_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          div_d   = clamp_div(baud_q);
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == div_q - 16'd1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == div_q - 16'd1) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == div_q - 16'd1) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            div_d   = clamp_div(baud_q);
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      div_q   <= MIN_DIV;
      baud_q  <= CLKS_PER_BIT;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      idle_q  <= (state_d == StIdle);
      if (baud_wr) baud_q <= data_in[15:0];
      if (drop) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign tx   = tx_q;
  assign idle = idle_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised scoreboard bench for uart_tx_mmio: writes queue expected frames,
// an independent line monitor decodes tx and compares.
module tb_uart_tx_mmio;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        we = 1'b0;
  logic [31:0] data_out;
  logic        tx, idle;

  uart_tx_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .tx       (tx),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: {divisor, byte} per accepted push, in send order.
  logic [23:0] exp_q[$];
  int          pushed = 0;
  int          started = 0;
  logic        ovf_m = 1'b0;
  logic [15:0] baud_m = 16'd434;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy_m);
    int occ;
    occ = pushed - started;
    return {23'b0, 5'(occ), ovf_m, occ == 0, occ == DEPTH, busy_m};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [15:0] div;
    if (a[31:4] != 28'h000_0100) return;
    case (a[3:2])
      2'd0: begin
        if (pushed - started < DEPTH) begin
          div = (baud_m < 16'd2) ? 16'd2 : baud_m;
          exp_q.push_back({div, d[7:0]});
          pushed++;
        end else begin
          ovf_m = 1'b1;
        end
      end
      2'd1: if (d[3]) ovf_m = 1'b0;
      2'd2: baud_m = d[15:0];
      default: ;
    endcase
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    we = 1'b1;
    model_write(a, d);
    @(posedge clk);
    #1;
    we = 1'b0;
    address = '0;
    data_in = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
    address = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && idle === 1'b1) && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", t < 20000, 1'b1);
  endtask

  // Line monitor: every falling start bit pops one expected frame and checks
  // each cycle of its 10 bit periods.
  initial begin : monitor
    logic [23:0] e;
    logic [9:0]  pat;
    logic [7:0]  got;
    int          div, bad;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        started++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          div = int'(e[23:8]);
          pat = {1'b1, e[7:0], 1'b0};
          bad = 0;
          got = '0;
          aborted = 1'b0;
          for (int k = 0; k < 10 * div; k++) begin
            if (k > 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== pat[k / div]) bad++;
            if ((k % div) == (div / 2) && k / div >= 1 && k / div <= 8) got[k / div - 1] = tx;
          end
          if (!aborted) begin
            check("frame_byte", {24'b0, got}, {24'b0, e[7:0]});
            check("frame_timing", bad, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] r;
    int          n;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and readback
    rd(32'h1004, r); check("reset_status", r, 32'h4);
    rd(32'h1008, r); check("reset_bauddiv", r, 32'd434);
    check("reset_tx", tx, 1'b1);
    check("reset_idle", idle, 1'b1);
    @(posedge clk); #1;

    // Single byte, first-frame latency and idle timing
    wr(32'h1008, 32'd4);
    wr(32'h1000, 32'hA5);                     // now at N+#1
    check("n_idle", idle, 1'b1);
    check("n_tx", tx, 1'b1);
    rd(32'h1004, r); check("n_status", r, exp_status(1'b0));
    @(posedge clk); #1;                       // N+1
    check("n1_tx", tx, 1'b0);
    check("n1_idle", idle, 1'b0);
    repeat (39) @(posedge clk);
    #1 check("n40_idle", idle, 1'b0);
    @(posedge clk); #1;
    check("n41_idle", idle, 1'b1);

    // Back-to-back frames are contiguous: 40 cycles total at div 2
    wr(32'h1008, 32'd2);
    wr(32'h1000, 32'h00);                     // N
    wr(32'h1000, 32'hFF);                     // N+1
    check("b2b_tx", tx, 1'b0);
    repeat (39) @(posedge clk);
    #1 check("b2b_n40_idle", idle, 1'b0);
    @(posedge clk); #1;
    check("b2b_n41_idle", idle, 1'b1);

    // Overflow with a frame in flight
    wr(32'h1008, 32'd4);
    wr(32'h1000, 32'h3C);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) wr(32'h1000, $urandom);
    rd(32'h1004, r); check("ovf_status", r, exp_status(1'b1));
    check("ovf_expect_bits", r[8:0], 9'h08B);
    wr(32'h1004, 32'h8);
    rd(32'h1004, r); check("ovf_cleared", r, exp_status(1'b1));
    wait_drain();

    // Divisor clamp and mid-frame divisor change
    wr(32'h1008, 32'd0);
    rd(32'h1008, r); check("clamp_readback", r, 32'd0);
    wr(32'h1000, 32'h5A);
    repeat (3) @(posedge clk);
    #1;
    wr(32'h1008, 32'd3);
    wr(32'h1000, 32'h96);
    wait_drain();

    // Decode misses and the unused offset
    wr(32'h1008, 32'd4);
    wr(32'h2000, 32'h55);
    wr(32'h100C, 32'hFF);
    wr(32'h2008, 32'h7);
    rd(32'h100C, r); check("rd_0c", r, 32'h0);
    rd(32'h2004, r); check("rd_miss", r, 32'h0);
    rd(32'h1008, r); check("baud_kept", r, 32'd4);
    rd(32'h1000, r); check("rd_txdata", r, 32'h0);
    @(posedge clk); #1;
    rd(32'h1004, r); check("miss_status", r, exp_status(1'b0));
    repeat (20) @(posedge clk);
    #1 check("miss_idle", idle, 1'b1);

    // Reset in the middle of a data bit with a byte still queued
    wr(32'h1000, 32'h81);
    wr(32'h1000, 32'h42);
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_idle", idle, 1'b1);
    rd(32'h1004, r); check("rst_status", r, 32'h4);
    rd(32'h1008, r); check("rst_baud", r, 32'd434);
    reset = 1'b0;
    exp_q.delete();
    pushed = started;
    ovf_m = 1'b0;
    baud_m = 16'd434;
    @(posedge clk); #1;

    // Randomised bursts at random divisors
    for (int it = 0; it < 20; it++) begin
      wr(32'h1008, $urandom_range(0, 5));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        wr(32'h1000, $urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
